// File: rtl/fpconv_pkg.sv
// fpconv_pkg: shared types and the native-to-memory conversion helper for
// the FP store-data path.
//
// Native register layout (82 bits):
//   [81] sign, [80:64] exponent (bias 0xFFFF, all-ones = Inf/NaN),
//   [63:0] significand with explicit integer bit at [63].
// Memory-format denormals appear natively with the target's minimum normal
// exponent and integer bit 0; they are passed through unchanged here.
package fpconv_pkg;

  localparam int NATIVE_W = 82;
  localparam int STQ_TAGW = 6;

  typedef enum logic [1:0] {
    SRC_ILL  = 2'b00,
    SRC_SNGL = 2'b01,
    SRC_DBL  = 2'b10,
    SRC_EXT  = 2'b11
  } fp_src_e;

  typedef enum logic {
    DST_S = 1'b0,
    DST_D = 1'b1
  } fp_dst_e;

  typedef struct packed {
    logic [63:0]         data;
    logic [STQ_TAGW-1:0] tag;
    logic                port;
    logic                err;
  } stconv_ent_t;

  typedef struct packed {
    logic [63:0] bits;
    logic        denorm;
  } cvt_res_t;

  // Truncating native -> IEEE conversion (single when dbl=0, double when 1).
  // Too-large exponents saturate to Inf. Unnormals above the target's
  // denormal range are never produced by the load converters and are
  // written as signed zero.
  function automatic cvt_res_t native_to_mem(input logic [NATIVE_W-1:0] n,
                                             input logic dbl);
    cvt_res_t    r;
    logic [16:0] e;
    logic [63:0] sig, frac, emax, mag;
    int          te, sh, mw, ew, bias;
    e    = n[80:64];
    sig  = n[63:0];
    mw   = dbl ? 52 : 23;
    ew   = dbl ? 11 : 8;
    bias = dbl ? 1023 : 127;
    emax = dbl ? 64'h7FF : 64'hFF;
    frac = (sig << 1) >> (64 - mw);
    te   = int'({15'd0, e}) - 65535 + bias;
    r.denorm = 1'b0;
    mag      = '0;
    if (e == 17'h1FFFF)
      mag = (emax << mw) | frac;
    else if (sig == '0)
      mag = '0;
    else if (sig[63] && te >= 1)
      mag = (te >= int'(emax)) ? (emax << mw) : ((64'(te) << mw) | frac);
    else if (te <= 1) begin
      // below min normal: shift so the significand lands in the fraction
      sh  = 1 - te + 63 - mw;
      mag = (sh >= 64) ? '0 : (sig >> sh);
      r.denorm = (mag != '0);
    end
    r.bits = (64'(n[81]) << (ew + mw)) | mag;
    return r;
  endfunction

endpackage

// File: rtl/fp_stconv_cvt.sv
// Native-to-memory store converters.
//   stNativeS2S: native -> 32-bit single. Inputs din, from_s/from_d/from_e
//                (source format enables); outputs dout, denorm.
//   stNativeD2D: native -> 64-bit double. Inputs din, from_d/from_e;
//                outputs dout, denorm.
// With no enable asserted, outputs are zero.
module stNativeS2S
  import fpconv_pkg::*;
(
  input  logic [NATIVE_W-1:0] din,
  input  logic                from_s,
  input  logic                from_d,
  input  logic                from_e,
  output logic [31:0]         dout,
  output logic                denorm
);
  cvt_res_t    r;
  logic [31:0] unused_hi;

  always_comb begin
    r      = native_to_mem(din, 1'b0);
    dout   = '0;
    denorm = 1'b0;
    if (from_s | from_d | from_e) begin
      dout   = r.bits[31:0];
      denorm = r.denorm;
    end
  end
  assign unused_hi = r.bits[63:32];
endmodule

module stNativeD2D
  import fpconv_pkg::*;
(
  input  logic [NATIVE_W-1:0] din,
  input  logic                from_d,
  input  logic                from_e,
  output logic [63:0]         dout,
  output logic                denorm
);
  cvt_res_t r;

  always_comb begin
    r      = native_to_mem(din, 1'b1);
    dout   = '0;
    denorm = 1'b0;
    if (from_d | from_e) begin
      dout   = r.bits;
      denorm = r.denorm;
    end
  end
endmodule

// File: rtl/fp_stconv_q2.sv
// fp_stconv_q2: 2-entry FIFO for converted store data.
//   push/din  : write an entry (caller guarantees cnt<2 or pop)
//   pop       : drop the head (caller guarantees cnt>0)
//   flush     : empty the queue, dominates push/pop
//   head, cnt : head entry (registered) and occupancy
// Entries shift toward e0 so the head is a flop, not a mux.
module fp_stconv_q2
  import fpconv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  stconv_ent_t din,
  output stconv_ent_t head,
  output logic [1:0]  cnt
);
  stconv_ent_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din;
          else               e1_d = din;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) e0_d = din;
          else begin
            e0_d = e1_q;
            e1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head = e0_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/fp_stconv_sched.sv
// fp_stconv_sched: arbitrates two store-data requesters onto one shared
// pair of native->memory converters, registers the request in S1, and
// buffers converted results in a 2-entry output queue.
//   req_vld/req_rdy/req_data/req_src/req_dst/req_tag : requester side
//   flush  : synchronous kill of S1 and queue (prio kept)
//   out_*  : result stream (valid/ready), driven from queue head
//   busy   : S1 or queue occupied
// Optional macro FP_STCONV_FTZ_EN: denormal results become signed zero.
// TAGW must equal fpconv_pkg::STQ_TAGW (queue entry tag width).
module fp_stconv_sched
  import fpconv_pkg::*;
#(
  parameter int TAGW = STQ_TAGW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_vld,
  output logic [1:0]               req_rdy,
  input  logic [1:0][NATIVE_W-1:0] req_data,
  input  logic [1:0][1:0]          req_src,
  input  logic [1:0]               req_dst,
  input  logic [1:0][TAGW-1:0]     req_tag,
  input  logic                     flush,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [63:0]              out_data,
  output logic [TAGW-1:0]          out_tag,
  output logic                     out_port,
  output logic                     out_err,
  output logic                     busy
);
  typedef struct packed {
    logic [NATIVE_W-1:0] data;
    logic [1:0]          src;
    logic                dst;
    logic [TAGW-1:0]     tag;
    logic                port;
  } s1_t;

  logic        prio_q, prio_d, s1_vld_q, s1_vld_d;
  s1_t         s1_q, s1_d;
  logic [1:0]  q_cnt;
  stconv_ent_t q_head, q_din;
  logic        gnt, acc, pop, push, s1_adv, s1_ld_ok;
  logic        s2s_sel, d2d_sel, s2s_dn, d2d_dn;
  logic [31:0] s2s_out;
  logic [63:0] d2d_out;

  // Arbitration and S1 load control
  always_comb begin
    pop      = (q_cnt != 2'd0) & out_rdy;
    s1_adv   = s1_vld_q & ((q_cnt != 2'd2) | pop);
    s1_ld_ok = ~s1_vld_q | s1_adv;
    gnt      = req_vld[prio_q] ? prio_q : ~prio_q;
    // rst gating keeps req_rdy low for the whole reset window
    acc      = (|req_vld) & s1_ld_ok & ~flush & rst;
    req_rdy  = 2'b00;
    if (acc) req_rdy[gnt] = 1'b1;
    prio_d   = acc ? ~gnt : prio_q;
    push     = s1_adv & ~flush;

    s1_vld_d = s1_vld_q;
    if (flush)       s1_vld_d = 1'b0;
    else if (acc)    s1_vld_d = 1'b1;
    else if (s1_adv) s1_vld_d = 1'b0;

    s1_d = s1_q;
    if (acc) begin
      s1_d.data = req_data[gnt];
      s1_d.src  = req_src[gnt];
      s1_d.dst  = req_dst[gnt];
      s1_d.tag  = req_tag[gnt];
      s1_d.port = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      prio_q   <= prio_d;
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
    end
  end

  // Converter selection; anything not selected is an illegal combination
  assign s2s_sel = s1_vld_q & (s1_q.dst == DST_S) & (s1_q.src != SRC_ILL);
  assign d2d_sel = s1_vld_q & (s1_q.dst == DST_D) &
                   ((s1_q.src == SRC_DBL) | (s1_q.src == SRC_EXT));

  stNativeS2S u_s2s (
    .din    (s1_q.data),
    .from_s (s2s_sel & (s1_q.src == SRC_SNGL)),
    .from_d (s2s_sel & (s1_q.src == SRC_DBL)),
    .from_e (s2s_sel & (s1_q.src == SRC_EXT)),
    .dout   (s2s_out),
    .denorm (s2s_dn)
  );

  stNativeD2D u_d2d (
    .din    (s1_q.data),
    .from_d (d2d_sel & (s1_q.src == SRC_DBL)),
    .from_e (d2d_sel & (s1_q.src == SRC_EXT)),
    .dout   (d2d_out),
    .denorm (d2d_dn)
  );

  always_comb begin
    q_din      = '0;
    q_din.tag  = s1_q.tag;
    q_din.port = s1_q.port;
    q_din.err  = ~(s2s_sel | d2d_sel);
    if (s2s_sel)      q_din.data = {32'd0, s2s_out};
    else if (d2d_sel) q_din.data = d2d_out;
`ifdef FP_STCONV_FTZ_EN
    if (s2s_sel & s2s_dn) q_din.data = {32'd0, s2s_out[31], 31'd0};
    if (d2d_sel & d2d_dn) q_din.data = {d2d_out[63], 63'd0};
`endif
  end

`ifndef FP_STCONV_FTZ_EN
  logic unused_dn;
  assign unused_dn = s2s_dn ^ d2d_dn;
`endif

  fp_stconv_q2 u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .head  (q_head),
    .cnt   (q_cnt)
  );

  assign out_vld  = (q_cnt != 2'd0);
  assign out_data = q_head.data;
  assign out_tag  = q_head.tag;
  assign out_port = q_head.port;
  assign out_err  = q_head.err;
  assign busy     = s1_vld_q | out_vld;
endmodule

// File: tb/tb_fp_stconv_sched.sv
// Bench for fp_stconv_sched: directed scenarios followed by a randomized
// phase, all checked each cycle against a queue-based reference model.
// Expected memory images come from the original random IEEE values; the
// native operand is built by a load-style expansion of that value.
module tb_fp_stconv_sched;
  typedef struct packed {
    logic [81:0] nat;
    logic [1:0]  src;
    logic        dst;
    logic [5:0]  tag;
    logic [63:0] img;
    logic        err;
  } req_t;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  tag;
    logic        port;
    logic        err;
  } ment_t;

  logic             clk, rst, flush, out_rdy;
  logic [1:0]       req_vld, req_rdy, req_dst;
  logic [1:0][81:0] req_data;
  logic [1:0][1:0]  req_src;
  logic [1:0][5:0]  req_tag;
  logic             out_vld, out_port, out_err, busy;
  logic [63:0]      out_data;
  logic [5:0]       out_tag;

  int    tests = 0, fails = 0, n_acc0;
  req_t  cur[2];
  ment_t mq[$];
  ment_t m_s1;
  logic  m_s1_vld, m_prio;
  logic [1:0] last_acc;

  fp_stconv_sched #(.TAGW(6)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_data(req_data), .req_src(req_src), .req_dst(req_dst),
    .req_tag(req_tag), .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_tag(out_tag), .out_port(out_port),
    .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] exp, input logic [63:0] obs);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // IEEE image -> native register value (what a load would produce)
  function automatic logic [81:0] ld(input logic [63:0] img, input logic dbl);
    int mw, bias;
    logic [63:0] m, sig;
    logic [10:0] e, emax;
    logic [16:0] ne;
    logic        s;
    if (dbl) begin
      s = img[63]; e = img[62:52]; m = {12'd0, img[51:0]};
      mw = 52; bias = 1023; emax = 11'h7FF;
    end else begin
      s = img[31]; e = {3'd0, img[30:23]}; m = {41'd0, img[22:0]};
      mw = 23; bias = 127; emax = 11'h0FF;
    end
    if (e == emax) begin
      ne = 17'h1FFFF; sig = 64'h8000_0000_0000_0000 | (m << (63 - mw));
    end else if (e == 11'd0 && m == 64'd0) begin
      ne = 17'd0; sig = 64'd0;
    end else if (e == 11'd0) begin
      ne = 17'(65535 - bias + 1); sig = m << (63 - mw);
    end else begin
      ne = 17'(int'(e) - bias + 65535);
      sig = 64'h8000_0000_0000_0000 | (m << (63 - mw));
    end
    return {s, ne, sig};
  endfunction

  function automatic logic [63:0] rand_img(input logic dbl);
    int cat, emax;
    logic s;
    logic [10:0] e;
    logic [51:0] m;
    cat  = $urandom_range(0, 9);
    s    = 1'($urandom_range(0, 1));
    m    = 52'({$urandom, $urandom});
    emax = dbl ? 2047 : 255;
    if (!dbl) m = {29'd0, m[22:0]};
    case (cat)
      0:       begin e = 11'd0; m = 52'd0; end
      1:       begin e = 11'd0; m = m | 52'd1; end
      2:       e = 11'(emax);
      default: e = 11'($urandom_range(1, emax - 1));
    endcase
    return dbl ? {s, e, m} : {32'd0, s, e[7:0], m[22:0]};
  endfunction

  function automatic req_t make_req(input logic [1:0] src, input logic dst,
                                    input logic [63:0] img, input logic [5:0] tag);
    req_t r;
    logic dbl, dn;
    dbl   = !(src == 2'd1 || (src == 2'd3 && !dst));
    r.src = src; r.dst = dst; r.tag = tag;
    r.err = (src == 2'd0) || (src == 2'd1 && dst);
    r.nat = (src == 2'd0) ? {18'($urandom), $urandom, $urandom} : ld(img, dbl);
    dn    = dbl ? (img[62:52] == 11'd0 && img[51:0] != 52'd0)
                : (img[30:23] == 8'd0 && img[22:0] != 23'd0);
    r.img = r.err ? 64'd0 : img;
`ifdef FP_STCONV_FTZ_EN
    if (!r.err && dn) r.img = dbl ? {img[63], 63'd0} : {32'd0, img[31], 31'd0};
`else
    if (dn) r.img = r.img;
`endif
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [1:0] src;
    logic dst;
    case ($urandom_range(0, 5))
      0: begin src = 2'd1; dst = 1'b0; end
      1: begin src = 2'd2; dst = 1'b1; end
      2: begin src = 2'd3; dst = 1'b0; end
      3: begin src = 2'd3; dst = 1'b1; end
      4: begin src = 2'd1; dst = 1'b1; end
      default: begin src = 2'd0; dst = 1'($urandom_range(0, 1)); end
    endcase
    return make_req(src, dst, rand_img(!(src == 2'd1 || (src == 2'd3 && !dst))),
                    6'($urandom));
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      req_data[i] = cur[i].nat;
      req_src[i]  = cur[i].src;
      req_dst[i]  = cur[i].dst;
      req_tag[i]  = cur[i].tag;
    end
  endtask

  task automatic model_reset();
    m_prio = 1'b0; m_s1_vld = 1'b0; mq.delete(); m_s1 = '0;
  endtask

  // One clock: called just after a negedge with inputs driven.
  task automatic tick();
    logic [1:0] er;
    logic g, ld_ok, pop_m, adv;
    #1;
    pop_m = (mq.size() > 0) && out_rdy;
    adv   = m_s1_vld && (mq.size() < 2 || pop_m);
    ld_ok = !m_s1_vld || adv;
    g     = req_vld[m_prio] ? m_prio : !m_prio;
    er    = 2'b00;
    if (rst && !flush && (|req_vld) && ld_ok) er[g] = 1'b1;
    chk("req_rdy", 64'(er), 64'(req_rdy));
    chk("out_vld", 64'(mq.size() > 0), 64'(out_vld));
    chk("busy", 64'(m_s1_vld || mq.size() > 0), 64'(busy));
    if (mq.size() > 0) begin
      chk("out_data", mq[0].data, out_data);
      chk("out_tag", 64'(mq[0].tag), 64'(out_tag));
      chk("out_port", 64'(mq[0].port), 64'(out_port));
      chk("out_err", 64'(mq[0].err), 64'(out_err));
    end
    if (req_rdy[0]) n_acc0++;
    @(posedge clk);
    last_acc = er;
    if (flush) begin
      m_s1_vld = 1'b0; mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (adv) mq.push_back(m_s1);
      if (|er) begin
        m_s1 = '{data: cur[g].img, tag: cur[g].tag, port: g, err: cur[g].err};
        m_s1_vld = 1'b1; m_prio = !g;
      end else if (adv) m_s1_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; #1;
    chk("rst_rdy", 64'd0, 64'(req_rdy));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_rdy = 1'b1; req_vld = 2'b11;
    cur[0] = rand_req(); cur[1] = rand_req(); drive();
    model_reset(); last_acc = 2'b00; n_acc0 = 0;
    #1;
    chk("rst_rdy", 64'd0, 64'(req_rdy));
    chk("rst_vld", 64'd0, 64'(out_vld));
    chk("rst_data", 64'd0, out_data);
    chk("rst_tag", 64'd0, 64'(out_tag));
    chk("rst_port", 64'd0, 64'(out_port));
    chk("rst_err", 64'd0, 64'(out_err));
    chk("rst_busy", 64'd0, 64'(busy));
    @(negedge clk);
    rst = 1'b1; req_vld = 2'b00;

    // single 1.0 on port 0, latency 2
    cur[0] = make_req(2'd1, 1'b0, 64'h3F80_0000, 6'h11); drive();
    req_vld = 2'b01; tick();
    chk("t1_acc", 64'd1, 64'(last_acc));
    req_vld = 2'b00; tick();
    chk("t1_vld", 64'd1, 64'(out_vld));
    chk("t1_data", 64'h0000_0000_3F80_0000, out_data);
    chk("t1_port", 64'd0, 64'(out_port));
    tick(); tick();

    // both ports, prio from reset: grants alternate 0,1,0,1
    do_reset();
    cur[0] = make_req(2'd2, 1'b1, 64'h4000_0000_0000_0000, 6'h20);
    cur[1] = make_req(2'd3, 1'b1, 64'hC008_0000_0000_0000, 6'h21); drive();
    req_vld = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_gnt", (i % 2 == 0) ? 64'd1 : 64'd2, 64'(last_acc));
    end
    req_vld = 2'b00;
    for (int i = 0; i < 4; i++) tick();

    // double denormal 0x1
    cur[0] = make_req(2'd2, 1'b1, 64'h1, 6'h05); drive();
    req_vld = 2'b01; tick(); req_vld = 2'b00; tick();
`ifdef FP_STCONV_FTZ_EN
    chk("t3_denorm", 64'h0, out_data);
`else
    chk("t3_denorm", 64'h1, out_data);
`endif
    tick();

    // backpressure: 3 accepts then stall, drain in order
    out_rdy = 1'b0; req_vld = 2'b01; n_acc0 = 0;
    for (int i = 0; i < 6; i++) begin
      cur[0] = make_req(2'd1, 1'b0, rand_img(1'b0), 6'(8 + i)); drive();
      if (last_acc[0] || i == 0) ; // new record each cycle is harmless
      tick();
    end
    chk("t4_accepts", 64'd3, 64'(n_acc0));
    chk("t4_stall_rdy", 64'd0, 64'(req_rdy));
    out_rdy = 1'b1; req_vld = 2'b00;
    for (int i = 0; i < 5; i++) tick();

    // illegal combinations
    cur[0] = make_req(2'd1, 1'b1, 64'h3F80_0000, 6'h30);
    cur[1] = make_req(2'd0, 1'b0, 64'h0, 6'h31); drive();
    req_vld = 2'b11; tick(); tick(); req_vld = 2'b00; tick();
    chk("t5_err", 64'd1, 64'(out_err));
    chk("t5_data", 64'd0, out_data);
    tick(); tick();

    // flush with 3 results held
    out_rdy = 1'b0; req_vld = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1; tick();
    chk("t6_flush_rdy", 64'd0, 64'(last_acc));
    flush = 1'b0; req_vld = 2'b00; #1;
    chk("t6_vld", 64'd0, 64'(out_vld));
    chk("t6_busy", 64'd0, 64'(busy));
    @(negedge clk);
    out_rdy = 1'b1;
    cur[1] = make_req(2'd2, 1'b1, 64'h3FF0_0000_0000_0000, 6'h3A); drive();
    req_vld = 2'b10; tick(); req_vld = 2'b00; tick();
    chk("t6_lat_vld", 64'd1, 64'(out_vld));
    chk("t6_lat_data", 64'h3FF0_0000_0000_0000, out_data);
    tick();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_vld = 2'($urandom);
      out_rdy = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 49) == 0);
      tick();
      for (int i = 0; i < 2; i++) if (last_acc[i]) cur[i] = rand_req();
      drive();
    end
    flush = 1'b0;

    // reset in mid-operation discards everything at once
    out_rdy = 1'b0; req_vld = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b0; #1;
    chk("mr_vld", 64'd0, 64'(out_vld));
    chk("mr_busy", 64'd0, 64'(busy));
    chk("mr_rdy", 64'd0, 64'(req_rdy));
    chk("mr_data", 64'd0, out_data);
    model_reset();
    @(negedge clk);
    rst = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    req_vld = 2'b00;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_stconv_sched.md
# fp_stconv_sched

Store-data conversion scheduler for the FP load/store unit. It arbitrates two store-data requesters onto one shared pair of native-to-memory converters (stNativeS2S, stNativeD2D) and registers the request into a pipeline stage. It buffers converted results in a 2-entry output queue with valid/ready backpressure. It sits between the store-data read ports of the FP register file and the store queue data write port.

## Interface
- TAGW, 6, store-queue tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_vld  in  2  per-requester request valid
- req_rdy  out  2  per-requester accept; transfer when vld&rdy
- req_data  in  2x82  native FP register value
- req_src  in  2x2  native format: 01 single, 10 double, 11 extended, 00 illegal
- req_dst  in  2  memory format: 0 single (32b), 1 double (64b)
- req_tag  in  2xTAGW  store-queue tag
- flush  in  1  synchronous kill of all in-flight work
- out_vld  out  1  result valid
- out_rdy  in  1  consumer accept
- out_data  out  64  memory image; single in [31:0], [63:32]=0
- out_tag  out  TAGW  tag of result
- out_port  out  1  requester index of result
- out_err  out  1  illegal format combination; out_data=0
- busy  out  1  S1 or queue non-empty

## Operation
- Round-robin arbiter, one grant per cycle. Pointer `prio` (reset 0) names the preferred requester. If both are valid, the preferred one wins. If only one is valid, it wins. After any grant, `prio` moves to the non-granted index.
- req_rdy[i] is asserted only for the granted requester, and only when S1 can load: S1 empty, or S1 advancing this cycle.
- S1 register holds data, src, dst, tag, port.
- Converters are driven combinationally from S1:
  - dst=0: stNativeS2S, from_* decoded from src.
  - dst=1, src∈{10,11}: stNativeD2D.
  - dst=1, src=01, or src=00: out_err=1, data 0, no converter enable.
- S1 advances into the output queue when the queue is not full or is popping this cycle.
- Output queue: 2 entries, FIFO order. out_* are driven from the head entry. A simultaneous push and pop with count=2 is legal and the count stays 2.
- Full throughput: 1 conversion per cycle with out_rdy held high.
- flush:
  - Clears S1 valid and the queue count.
  - Forces req_rdy=0 in the same cycle.
  - prio is unchanged.
  - out_vld drops the next cycle.
- Reset values: out_vld=0, out_data=0, out_tag=0, out_port=0, out_err=0, busy=0, req_rdy=00 while rst low, prio=0, queue empty.
- Reset asserted mid-operation discards S1 and the queue immediately; no partial output.

## Timing
- Accept at edge T (vld&rdy high in the cycle before T): S1 valid after T, result enters the queue at T+1, out_vld high in the cycle after T+1. Latency is 2 cycles.
- Backpressure: with out_rdy=0 the pipeline holds 3 results (2 queue + S1); then req_rdy=00.
- req_rdy is combinational from S1 valid, queue count, out_rdy, req_vld and prio. There are no combinational paths from req_data to any output.
- out_* are registered (queue outputs) and stable while out_vld&~out_rdy.

## Configuration
- FP_STCONV_FTZ_EN:
  - Defined: a result whose converter detects a denormal range (exponent field zero, nonzero mantissa) is replaced by signed zero before queue write.
  - Undefined: the converter's gradual-underflow result is passed unchanged.
  - Zero, overflow and NaN handling is identical in both cases.

## Structure
- Shared package fpconv_pkg:
  - NATIVE_W=82.
  - Enum fp_src_e {SRC_ILL, SRC_SNGL, SRC_DBL, SRC_EXT}.
  - Enum fp_dst_e {DST_S, DST_D}.
  - Packed struct stconv_ent_t {data, tag, port, err}.
- One sub-module, fp_stconv_q2: the 2-entry output queue with count, push/pop/flush, and async active-low reset.
- The arbiter and S1 stay in the top module. Converters are instantiated once each.

## Test plan
- Single request, port 0, native single of 1.0 (via ldS2nativeS of 0x3F800000), dst=0 -> out_data=0x0000_0000_3F80_0000, out_port=0, out_vld two cycles after accept.
- Both ports valid for 4 cycles, out_rdy=1, prio=0 -> grants 0,1,0,1; out_port sequence 0,1,0,1; one result per cycle.
- Native double of 0x0000_0000_0000_0001 (denormal), dst=1 -> out_data=0x1 without FP_STCONV_FTZ_EN; 0x0 with FP_STCONV_FTZ_EN.
- out_rdy=0 with port 0 streaming -> 3 accepts then req_rdy=00. Raising out_rdy drains results in accept order with tags intact.
- src=01, dst=1 -> out_err=1, out_data=0. src=00 -> out_err=1.
- Flush with 3 results held -> out_vld=0 the next cycle, busy=0, req_rdy=00 in the flush cycle. A later request completes normally with latency 2.
